// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: command and state encodings shared by the SR flip-flop driver
package sr_drv_pkg;
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_RST = 2'b10,
        OP_TGL = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_t;
endpackage

// File: rtl/sr_drv_timer.sv
// sr_drv_timer: loadable down-counter with zero flag, shared by DRIVE and CHECK
//   clk, rst_n : clock, async active-low reset
//   load, val  : load val on the next rising edge (priority over counting)
//   zero       : counter is zero; counting stops there
module sr_drv_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: issues one S or R pulse per command to a falling-edge SR flip-flop and verifies Q
//   req_valid/req_op/req_ready : command handshake (NOP, SET, RESET, TOGGLE)
//   S, R                       : registered, mutually exclusive drives to the flip-flop
//   q_fb                       : Q feedback from the flip-flop
//   done / err                 : one-cycle completion / timeout pulses
//   busy, err_count            : in DRIVE or CHECK; saturating count of err pulses
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 4,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);
    localparam int MAXC = PULSE_CYCLES > TIMEOUT_CYCLES ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(MAXC) > 0 ? $clog2(MAXC) : 1;
    state_t        state, state_n;
    logic          tgt, tgt_n, s_n, r_n, done_n, err_n, tload, tzero;
    logic [TW-1:0] tval;
    sr_drv_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tload),
        .val  (tval),
        .zero (tzero)
    );
    // Timer is loaded with (edges - 1) so the zero flag marks the last edge of a phase.
    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        s_n     = 1'b0;
        r_n     = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        tload   = 1'b0;
        tval    = '0;
        case (state)
            IDLE: if (req_valid) begin
                if (req_op == OP_NOP) done_n = 1'b1;
                else begin
                    tgt_n   = req_op == OP_SET ? 1'b1 : req_op == OP_RST ? 1'b0 : ~q_fb;
                    s_n     = tgt_n;
                    r_n     = ~tgt_n;
                    tload   = 1'b1;
                    tval    = TW'(PULSE_CYCLES - 1);
                    state_n = DRIVE;
                end
            end
            DRIVE: if (tzero) begin
                tload   = 1'b1;
                tval    = TW'(TIMEOUT_CYCLES - 1);
                state_n = CHECK;
            end else begin
                s_n = tgt;
                r_n = ~tgt;
            end
            CHECK: begin
                done_n  = q_fb == tgt;
                err_n   = q_fb != tgt && tzero;
                state_n = done_n || err_n ? IDLE : CHECK;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            S     <= s_n;
            R     <= r_n;
            done  <= done_n;
            err   <= err_n;
            if (err_n && err_count != '1) err_count <= err_count + ERR_W'(1);
        end
    end
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_sr_ff_driver.sv
// tb_sr_ff_driver: directed self-checking bench with a behavioural falling-edge SR flip-flop
module tb_sr_ff_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic       req_ready, S, R, done, err, busy;
    logic [7:0] err_count;
    logic       q = 1'b0;
    logic       stuck = 1'b0;
    logic       q_fb;
    int         checks = 0;
    int         errors = 0;

    assign q_fb = stuck ? 1'b0 : q;

    sr_ff_driver #(.PULSE_CYCLES(1), .TIMEOUT_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .S(S), .R(R), .q_fb(q_fb), .done(done),
        .err(err), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (S) q <= 1'b1;
        else if (R) q <= 1'b0;
    end

    always @(posedge clk) begin
        checks++;
        assert (!(S && R)) else begin
            errors++;
            $error("FAIL sr_exclusive: S=%0b R=%0b required not both high", S, R);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op);
        req_valid = 1'b1;
        req_op    = op;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errcnt", err_count, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        chk("rst_ready", req_ready, 1);

        // SET from Q=0
        send(2'b01);
        chk("set_S", S, 1);
        chk("set_R", R, 0);
        chk("set_busy", busy, 1);
        chk("set_ready", req_ready, 0);
        tick();
        chk("set_S_off", S, 0);
        chk("set_q", q_fb, 1);
        chk("set_nodone_k1", done, 0);
        tick();
        chk("set_done", done, 1);
        chk("set_idle", busy, 0);
        chk("set_errcnt", err_count, 0);
        tick();
        chk("set_done_pulse", done, 0);

        // TOGGLE from Q=1 then back
        send(2'b11);
        chk("tgl1_S", S, 0);
        chk("tgl1_R", R, 1);
        tick();
        chk("tgl1_R_off", R, 0);
        tick();
        chk("tgl1_done", done, 1);
        chk("tgl1_q", q_fb, 0);
        send(2'b11);
        chk("tgl2_S", S, 1);
        chk("tgl2_R", R, 0);
        tick();
        tick();
        chk("tgl2_done", done, 1);
        chk("tgl2_q", q_fb, 1);

        // NOP
        send(2'b00);
        chk("nop_done", done, 1);
        chk("nop_busy", busy, 0);
        chk("nop_ready", req_ready, 1);
        chk("nop_SR", {S, R}, 0);
        tick();
        chk("nop_done_off", done, 0);

        // Stuck-at-0 feedback: timeout
        stuck = 1'b1;
        send(2'b01);
        chk("stk_S", S, 1);
        tick();
        chk("stk_S_off", S, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stk_wait", {done, err, busy}, 3'b001);
        end
        tick();
        chk("stk_err", err, 1);
        chk("stk_done", done, 0);
        chk("stk_errcnt1", err_count, 1);
        tick();
        chk("stk_err_pulse", err, 0);
        for (int i = 1; i < 300; i++) begin
            send(2'b01);
            repeat (5) tick();
            if (i == 254) chk("stk_errcnt255", err_count, 255);
        end
        chk("stk_errcnt_sat", err_count, 255);
        stuck = 1'b0;

        // Clear Q, then SET with RESET requested while busy
        send(2'b10);
        tick();
        tick();
        chk("rst_cmd_q", q_fb, 0);
        send(2'b01);
        req_valid = 1'b1;
        req_op    = 2'b10;
        tick();
        chk("bsy_SR", {S, R}, 0);
        chk("bsy_ready", req_ready, 0);
        tick();
        chk("bsy_done", done, 1);
        chk("bsy_noR", R, 0);
        chk("bsy_q", q_fb, 1);
        tick();
        chk("bsy_R", R, 1);
        chk("bsy_S", S, 0);
        req_valid = 1'b0;
        req_op    = 2'b01;
        tick();
        chk("bsy_R_off", R, 0);
        tick();
        chk("bsy_done2", done, 1);
        chk("bsy_q2", q_fb, 0);

        // Reset during DRIVE
        send(2'b01);
        chk("abt_S_pre", S, 1);
        rst_n = 1'b0;
        #1;
        chk("abt_S", S, 0);
        chk("abt_busy", busy, 0);
        chk("abt_errcnt", err_count, 0);
        tick();
        tick();
        chk("abt_nopulse", {done, err}, 0);
        #2 rst_n = 1'b1;
        send(2'b01);
        chk("post_S", S, 1);
        tick();
        tick();
        chk("post_done", done, 1);
        chk("post_q", q_fb, 1);
        chk("post_err", err, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
